// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- MEM-stage request/response bundle for dmem_responder.
// The master (MEM stage or bench) drives requests; the slave (responder)
// returns data, the completion pulse, the busy indication and the error pulse.
interface dmem_responder_if;
    logic        memRd;
    logic        memWr;
    logic [15:0] memAddr;
    logic [15:0] wrData;
    logic [15:0] rdData;
    logic        ack;
    logic        busy;
    logic        err;

    modport master (
        output memRd, memWr, memAddr, wrData,
        input  rdData, ack, busy, err
    );

    modport slave (
        input  memRd, memWr, memAddr, wrData,
        output rdData, ack, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- fixed-latency 16-bit data memory responder.
// IDLE samples a request, WAIT counts LATENCY cycles, RESP completes the
// access; ack rises LATENCY+1 edges after the accept edge and no request is
// taken while ack is high.
// Optional feature: define DMEM_POSTWR_EN to add a single-entry posted-write
// buffer (writes ack one cycle after accept and commit LATENCY cycles later).
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  wr_q;
    logic                  ack_q;
    logic                  err_q;
    logic [15:0]           rd_data_q;

    logic [15:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_block;
    logic                  req_err;
    logic                  req_rd;
    logic                  req_wr;
    logic [15:0]           rd_value;

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_wa;
    logic [15:0]           mem_wd;

`ifdef DMEM_POSTWR_EN
    logic                  pb_valid_q;
    logic [3:0]            pb_cnt_q;
    logic [DEPTH_LOG2-1:0] pb_idx_q;
    logic [15:0]           pb_data_q;
`else
    logic [15:0]           data_q;
`endif

    // Upper address bits only alias; fold them into a deliberately unused sink.
    if (DEPTH_LOG2 < 16) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.memAddr[15:DEPTH_LOG2];
    end

    // Request decode: a request is seen only in IDLE outside the ack cycle.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        req_idx   = bus.memAddr[DEPTH_LOG2-1:0];
        req_block = (state_q != IDLE) || ack_q;
`ifdef DMEM_POSTWR_EN
        // A full buffer stalls the whole request while a write is presented.
        req_block = req_block || (pb_valid_q && bus.memWr);
`endif
        req_err = !req_block && bus.memRd && bus.memWr;
        req_rd  = !req_block && bus.memRd && !bus.memWr;
        req_wr  = !req_block && bus.memWr && !bus.memRd;
    end

    // Read data source for the RESP edge, forwarding a buffered write if present.
    always_comb begin
        rd_value = mem[idx_q];
`ifdef DMEM_POSTWR_EN
        if (pb_valid_q && (pb_idx_q == idx_q)) begin
            rd_value = pb_data_q;
        end
`endif
    end

    // Access FSM with registered ack, err and read data.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
`ifndef DMEM_POSTWR_EN
            data_q    <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            err_q <= req_err;
            case (state_q)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        idx_q <= req_idx;
                        wr_q  <= req_wr;
`ifdef DMEM_POSTWR_EN
                        if (req_wr) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
`else
                        data_q  <= bus.wrData;
                        state_q <= WAIT;
                        cnt_q   <= CNT_LOAD;
`endif
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    ack_q   <= 1'b1;
                    state_q <= IDLE;
                    if (!wr_q) begin
                        rd_data_q <= rd_value;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_POSTWR_EN
    // Posted-write buffer: fill on an accepted write, commit after LATENCY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb_valid_q <= 1'b0;
            pb_cnt_q   <= '0;
            pb_idx_q   <= '0;
            pb_data_q  <= '0;
        end else if (req_wr) begin
            pb_valid_q <= 1'b1;
            pb_cnt_q   <= CNT_LOAD;
            pb_idx_q   <= req_idx;
            pb_data_q  <= bus.wrData;
        end else if (pb_valid_q) begin
            if (pb_cnt_q == '0) begin
                pb_valid_q <= 1'b0;
            end else begin
                pb_cnt_q <= pb_cnt_q - 4'd1;
            end
        end
    end

    assign mem_we = pb_valid_q && (pb_cnt_q == '0);
    assign mem_wa = pb_idx_q;
    assign mem_wd = pb_data_q;
`else
    assign mem_we = (state_q == RESP) && wr_q;
    assign mem_wa = idx_q;
    assign mem_wd = data_q;
`endif

    // Memory write port.
    // NOTE: the array has no reset so it maps onto RAM and keeps its contents
    // across rst_n; aborted accesses never reach here because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign bus.rdData = rd_data_q;
    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
`ifdef DMEM_POSTWR_EN
    assign bus.busy   = (state_q != IDLE) || (pb_valid_q && bus.memWr);
`else
    assign bus.busy   = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- self-checking bench for dmem_responder.
// A transaction-level model predicts ack/err/busy/rdData every cycle from the
// request timeline; directed sequences add literal expectations. A second
// instance with LATENCY=1 exercises back-to-back reads held high.
// Honours DMEM_POSTWR_EN when the design is built with it.
module tb_dmem_responder;

    localparam int DEPTH_LOG2 = 10;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int LAT        = 3;
`ifdef DMEM_POSTWR_EN
    localparam bit POSTED     = 1'b1;
`else
    localparam bit POSTED     = 1'b0;
`endif
    localparam int WR_LAT     = POSTED ? 1 : LAT + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus  ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dmem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (edge-indexed timeline) -------------
    logic [15:0] m_mem [DEPTH];
    int          edge_n   = 0;
    int          free_at  = 0;    // first edge index at which a request is taken
    int          ack_at   = -1;   // edge index raising ack of the pending access
    bit          p_rd     = 1'b0;
    int          p_idx    = 0;
    logic [15:0] p_data   = '0;
    bit          pw_valid = 1'b0; // posted-write buffer occupancy
    int          pw_at    = 0;
    int          pw_idx   = 0;
    logic [15:0] pw_data  = '0;
    logic        exp_ack  = 1'b0;
    logic        exp_err  = 1'b0;
    logic [15:0] exp_rd   = '0;
    bit          cmp_en   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_ack  = 1'b0;
            exp_err  = 1'b0;
            exp_rd   = '0;
            ack_at   = -1;
            pw_valid = 1'b0;
            free_at  = edge_n + 1;
        end else begin
            int e;
            edge_n++;
            e       = edge_n;
            exp_ack = 1'b0;
            exp_err = 1'b0;
            if (ack_at == e) begin
                exp_ack = 1'b1;
                ack_at  = -1;
                if (p_rd) begin
                    exp_rd = (pw_valid && pw_idx == p_idx) ? pw_data : m_mem[p_idx];
                end else if (!POSTED) begin
                    m_mem[p_idx] = p_data;
                end
            end
            if (e >= free_at && (bus.memRd || bus.memWr) && !(POSTED && pw_valid && bus.memWr)) begin
                if (bus.memRd && bus.memWr) begin
                    exp_err = 1'b1;
                end else begin
                    p_rd   = bus.memRd;
                    p_idx  = int'(bus.memAddr) % DEPTH;
                    p_data = bus.wrData;
                    if (bus.memWr && POSTED) begin
                        ack_at   = e + 1;
                        pw_valid = 1'b1;
                        pw_at    = e + LAT;
                        pw_idx   = p_idx;
                        pw_data  = p_data;
                    end else begin
                        ack_at = e + LAT + 1;
                    end
                    free_at = ack_at + 2;
                end
            end
            if (pw_valid && pw_at == e) begin
                m_mem[pw_idx] = pw_data;
                pw_valid      = 1'b0;
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ack", bus.ack, exp_ack);
            check("err", bus.err, exp_err);
            check("busy", bus.busy, (ack_at != -1) || (POSTED && pw_valid && bus.memWr));
            check("rdData", bus.rdData, exp_rd);
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic do_op(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input int gap,
                         output int lat, output logic [15:0] rdv);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        bus.memRd   = rd;
        bus.memWr   = wr;
        bus.memAddr = addr;
        bus.wrData  = data;
        @(posedge clk); #1;
        bus.memRd = 1'b0;
        bus.memWr = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.ack) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        rdv = bus.rdData;
    endtask

    int idx_tab [8] = '{5, 3, 'h10, 'h11, 'h12, 'h22, 'h40, 'h3FF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [15:0] rdv;
        int          errs, acks, busys, stall;
        bit          prev_ack;

        bus.memRd = 1'b0;  bus.memWr = 1'b0;  bus.memAddr = '0;  bus.wrData = '0;
        bus1.memRd = 1'b0; bus1.memWr = 1'b0; bus1.memAddr = '0; bus1.wrData = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", bus.ack, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_rdData", bus.rdData, 16'h0000);
        cmp_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Preload the index set used by the random phase
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, 1'b1, 16'(idx_tab[i]), 16'(16'h1111 * (i + 1)), LAT + 2, lat, rdv);
        end

        // Write then read back 0xBEEF at 0x0005
        do_op(1'b0, 1'b1, 16'h0005, 16'hBEEF, LAT + 2, lat, rdv);
        check("beef_wr_latency", lat, WR_LAT);
        do_op(1'b1, 1'b0, 16'h0005, 16'h0000, LAT + 2, lat, rdv);
        check("beef_rd_latency", lat, 4);
        check("beef_rd_data", rdv, 16'hBEEF);
        check("model_beef", exp_rd, 16'hBEEF);

        // Read and write together: one err pulse, nothing else happens
        repeat (LAT + 2) @(posedge clk);
        #1;
        bus.memRd = 1'b1; bus.memWr = 1'b1; bus.memAddr = 16'h0005; bus.wrData = 16'hDEAD;
        @(posedge clk); #1;
        bus.memRd = 1'b0; bus.memWr = 1'b0;
        errs = 0; acks = 0; busys = 0;
        for (int k = 0; k < 6; k++) begin
            errs  += int'(bus.err);
            acks  += int'(bus.ack);
            busys += int'(bus.busy);
            @(posedge clk); #1;
        end
        check("both_err_pulses", errs, 1);
        check("both_no_ack", acks, 0);
        check("both_no_busy", busys, 0);
        do_op(1'b1, 1'b0, 16'h0005, 16'h0000, 0, lat, rdv);
        check("both_mem_unchanged", rdv, 16'hBEEF);

        // Address aliasing modulo 2^DEPTH_LOG2
        do_op(1'b0, 1'b1, 16'h0403, 16'h1234, LAT + 2, lat, rdv);
        do_op(1'b1, 1'b0, 16'h0003, 16'h0000, LAT + 2, lat, rdv);
        check("alias_rd_data", rdv, 16'h1234);
        check("model_alias", exp_rd, 16'h1234);

        // Reset in the middle of a write aborts it
        do_op(1'b0, 1'b1, 16'h0022, 16'h1111, LAT + 2, lat, rdv);
        repeat (LAT + 2) @(posedge clk);
        @(posedge clk); #1;
        bus.memWr = 1'b1; bus.memAddr = 16'h0022; bus.wrData = 16'h2222;
        @(posedge clk); #1;
        bus.memWr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ack", bus.ack, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_err", bus.err, 1'b0);
        check("abort_rdData", bus.rdData, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(1'b1, 1'b0, 16'h0022, 16'h0000, LAT + 2, lat, rdv);
        check("abort_old_value", rdv, 16'h1111);

`ifdef DMEM_POSTWR_EN
        // Posted write, immediate read, then a stalled second write
        do_op(1'b0, 1'b1, 16'h0010, 16'hA5A5, LAT + 2, lat, rdv);
        check("pw_wr_latency", lat, 1);
        do_op(1'b1, 1'b0, 16'h0010, 16'h0000, 0, lat, rdv);
        check("pw_rd_latency", lat, 4);
        check("pw_rd_data", rdv, 16'hA5A5);
        do_op(1'b0, 1'b1, 16'h0011, 16'h3333, LAT + 2, lat, rdv);
        bus.memWr = 1'b1; bus.memAddr = 16'h0012; bus.wrData = 16'h4444;
        #1;
        check("pw_stall_busy", bus.busy, 1'b1);
        stall = -1;
        for (int k = 1; k < 40; k++) begin
            @(posedge clk); #1;
            if (bus.ack) begin
                stall = k;
                break;
            end
        end
        bus.memWr = 1'b0;
        check("pw_stall_cycles", stall, LAT + 1);
`endif

        // Randomised traffic against the model, with one reset mid-stream
        for (int c = 0; c < 600; c++) begin
            int op;
            @(posedge clk); #1;
            if (c == 300) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            op = int'($urandom_range(0, 7));
            bus.memRd   = (op <= 2) || (op == 6);
            bus.memWr   = (op >= 3 && op <= 5) || (op == 6);
            bus.memAddr = {6'($urandom), 10'(idx_tab[$urandom_range(0, 7)])};
            bus.wrData  = 16'($urandom);
        end
        @(posedge clk); #1;
        bus.memRd = 1'b0; bus.memWr = 1'b0;
        repeat (10) @(posedge clk);

        // LATENCY=1: reads held high never produce adjacent ack cycles
        @(posedge clk); #1;
        bus1.memWr = 1'b1; bus1.memAddr = 16'h0007; bus1.wrData = 16'h5A5A;
        @(posedge clk); #1;
        bus1.memWr = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus1.memRd = 1'b1; bus1.memAddr = 16'h0007;
        prev_ack = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            // accept at sample 0, ack two edges later, next accept after the ack cycle
            check("l1_ack", bus1.ack, (k >= 2) && ((k - 2) % 4 == 0));
            if (bus1.ack) begin
                check("l1_no_adjacent_ack", prev_ack, 1'b0);
                check("l1_rd_data", bus1.rdData, 16'h5A5A);
            end
            prev_ack = bus1.ack;
        end
        bus1.memRd = 1'b0;
        repeat (4) @(posedge clk);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
